// File: rtl/mandelbrot_iter_ctrl.sv
// Per-pixel Mandelbrot iteration sequencer: holds c and z, steps z through an
// external combinational ALU once per clock, and reports the iteration count.
module mandelbrot_iter_ctrl #(
  parameter int WIDTH      = 8,
  parameter int ITER_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_cr,
  input  logic [WIDTH-1:0]      in_ci,
  input  logic [ITER_WIDTH-1:0] in_max_iter,
  output logic [WIDTH-1:0]      alu_cr,
  output logic [WIDTH-1:0]      alu_ci,
  output logic [WIDTH-1:0]      alu_zr,
  output logic [WIDTH-1:0]      alu_zi,
  input  logic [WIDTH-1:0]      alu_out_zr,
  input  logic [WIDTH-1:0]      alu_out_zi,
  input  logic                  alu_size,
  input  logic                  alu_overflow,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ITER_WIDTH-1:0] out_iter,
  output logic                  out_escaped
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WIDTH-1:0]      r_cr;
  logic [WIDTH-1:0]      r_ci;
  logic [WIDTH-1:0]      r_zr;
  logic [WIDTH-1:0]      r_zi;
  logic [ITER_WIDTH-1:0] r_iter;
  logic [ITER_WIDTH-1:0] r_max;
  logic                  r_escaped;
  logic [ITER_WIDTH-1:0] w_iter_next;
  logic                  w_escape;
  logic                  w_accept;

  assign w_iter_next = r_iter + ITER_WIDTH'(1);
  assign w_escape    = alu_size | alu_overflow;
  assign w_accept    = (r_state == S_IDLE) && in_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_next = (in_max_iter == '0) ? S_DONE : S_RUN;
      S_RUN:  if (w_escape || (w_iter_next == r_max)) w_state_next = S_DONE;
      S_DONE: if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cr      <= '0;
      r_ci      <= '0;
      r_zr      <= '0;
      r_zi      <= '0;
      r_iter    <= '0;
      r_max     <= '0;
      r_escaped <= 1'b0;
    end else if (w_accept) begin
      r_cr      <= in_cr;
      r_ci      <= in_ci;
      r_max     <= in_max_iter;
      r_zr      <= '0;
      r_zi      <= '0;
      r_iter    <= '0;
      r_escaped <= 1'b0;
    end else if (r_state == S_RUN) begin
      // An escaping z is kept as-is so the count reflects completed updates only.
      if (w_escape) begin
        r_escaped <= 1'b1;
      end else begin
        r_zr   <= alu_out_zr;
        r_zi   <= alu_out_zi;
        r_iter <= w_iter_next;
      end
    end
  end

  always_comb begin
    in_ready    = (r_state == S_IDLE);
    out_valid   = (r_state == S_DONE);
    out_iter    = r_iter;
    out_escaped = r_escaped;
    alu_cr      = r_cr;
    alu_ci      = r_ci;
    alu_zr      = r_zr;
    alu_zi      = r_zi;
  end

endmodule
